sp_ram_arbiter: RTL and testbench

- Shares one single-port 2048x16 RAM (sp_ram_16 instance, no output register, NORMAL_WRITE) between one write requester and one read requester.
- Issues at most one RAM access per cycle. Arbitration is round-robin or fixed-priority with starvation protection.
- Drives the RAM address, write data and write enable from registers, and returns read data with an aligned valid strobe.
- Sits between the pixel line-buffer writer and the downstream line reader.

---
 rtl/sp_ram_arbiter_if.sv | 38 +++
 rtl/sp_ram_arbiter.sv | 115 +++++++++++
 tb/tb_sp_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_arbiter_if.sv
// Bundle of signals between the line-buffer requesters, the arbiter and the
// single-port RAM.
//   slave  : arbiter view (takes requests and RAM read data, drives grants,
//            read return and the registered RAM controls)
//   master : requester/RAM view (the opposite directions)
//   write side : wr_req, wr_addr, wr_data -> wr_gnt
//   read side  : rd_req, rd_addr -> rd_gnt, rd_valid, rd_data
//   RAM side   : ram_addr, ram_wr_data, ram_wr_en -> RAM; ram_rd_data <- RAM
interface sp_ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;

  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_wr_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_rd_data,
    output wr_gnt, rd_gnt, rd_valid, rd_data, ram_addr, ram_wr_data, ram_wr_en
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_rd_data,
    input  wr_gnt, rd_gnt, rd_valid, rd_data, ram_addr, ram_wr_data, ram_wr_en
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM (no output register) between a single writer and
// a single reader, issuing at most one access per cycle.
//   clk  : clock for the arbiter and the RAM
//   rstn : asynchronous active-low reset
//   bus  : sp_ram_arbiter_if.slave
//          wr_gnt / rd_gnt are combinational accepts for the current cycle;
//          ram_addr / ram_wr_data / ram_wr_en are registered;
//          rd_valid marks rd_data two cycles after the read grant.
// ARB_MODE selects "RR" (alternate on contention) or a fixed priority
// ("WR_FIRST" / "RD_FIRST") where the loser is forced through after
// STARVE_LIMIT consecutive contested losses.
module sp_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter string       ARB_MODE     = "RR",
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rstn,
  sp_ram_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W   = 4;
  localparam bit          MODE_RR = (ARB_MODE == "RR");
  localparam bit          MODE_WF = (ARB_MODE == "WR_FIRST");
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wr_data_q;
  logic                  ram_wr_en_q;
  logic [1:0]            rd_vld_q;
  logic                  last_is_wr_q;
  logic [CNT_W-1:0]      wr_lose_q;
  logic [CNT_W-1:0]      rd_lose_q;

  logic                  win_wr;
  logic                  contested;
  logic                  wr_gnt_c;
  logic                  rd_gnt_c;
  logic [CNT_W-1:0]      wr_lose_d;
  logic [CNT_W-1:0]      rd_lose_d;

  // Contest winner and grants; gated by rstn so nothing is granted in reset
  always_comb begin
    win_wr = 1'b1;
    if (MODE_RR) begin
      win_wr = !last_is_wr_q;
    end else if (MODE_WF) begin
      win_wr = (rd_lose_q != LIMIT);
    end else begin
      win_wr = (wr_lose_q == LIMIT);
    end
    contested = rstn && bus.wr_req && bus.rd_req;
    wr_gnt_c  = rstn && bus.wr_req && (!bus.rd_req || win_wr);
    rd_gnt_c  = rstn && bus.rd_req && (!bus.wr_req || !win_wr);
  end

  // Starvation counters: bump the loser of a contest, clear on grant or drop
  always_comb begin
    wr_lose_d = wr_lose_q;
    rd_lose_d = rd_lose_q;
    if (MODE_RR || !bus.wr_req || wr_gnt_c) begin
      wr_lose_d = '0;
    end else if (contested && (wr_lose_q != LIMIT)) begin
      wr_lose_d = wr_lose_q + CNT_W'(1);
    end
    if (MODE_RR || !bus.rd_req || rd_gnt_c) begin
      rd_lose_d = '0;
    end else if (contested && (rd_lose_q != LIMIT)) begin
      rd_lose_d = rd_lose_q + CNT_W'(1);
    end
  end

  // RAM drive, read-valid pipeline and arbitration state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      ram_wr_en_q   <= 1'b0;
      rd_vld_q      <= '0;
      last_is_wr_q  <= 1'b0;
      wr_lose_q     <= '0;
      rd_lose_q     <= '0;
    end else begin
      if (wr_gnt_c) begin
        ram_addr_q    <= bus.wr_addr;
        ram_wr_data_q <= bus.wr_data;
        ram_wr_en_q   <= 1'b1;
      end else if (rd_gnt_c) begin
        ram_addr_q    <= bus.rd_addr;
        ram_wr_en_q   <= 1'b0;
      end else begin
        ram_wr_en_q   <= 1'b0;
      end
      // One stage covers the address register, the second the RAM read
      rd_vld_q <= {rd_vld_q[0], rd_gnt_c};
      if (wr_gnt_c) begin
        last_is_wr_q <= 1'b1;
      end else if (rd_gnt_c) begin
        last_is_wr_q <= 1'b0;
      end
      wr_lose_q <= wr_lose_d;
      rd_lose_q <= rd_lose_d;
    end
  end

  assign bus.wr_gnt      = wr_gnt_c;
  assign bus.rd_gnt      = rd_gnt_c;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wr_data = ram_wr_data_q;
  assign bus.ram_wr_en   = ram_wr_en_q;
  assign bus.rd_valid    = rd_vld_q[1];
  assign bus.rd_data     = bus.ram_rd_data;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: one "RR" and one "WR_FIRST" instance share the
// same request stimulus, each with its own RAM array and reference model.
module tb_sp_ram_arbiter;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 16;
  localparam int unsigned LIM   = 4;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_req;
  logic          rd_req;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] wr_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_rr ();
  sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_wf ();

  assign if_rr.wr_req  = wr_req;
  assign if_rr.wr_addr = wr_addr;
  assign if_rr.wr_data = wr_data;
  assign if_rr.rd_req  = rd_req;
  assign if_rr.rd_addr = rd_addr;
  assign if_wf.wr_req  = wr_req;
  assign if_wf.wr_addr = wr_addr;
  assign if_wf.wr_data = wr_data;
  assign if_wf.rd_req  = rd_req;
  assign if_wf.rd_addr = rd_addr;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE("RR"),
                   .STARVE_LIMIT(LIM))
    u_rr (.clk(clk), .rstn(rstn), .bus(if_rr.slave));

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE("WR_FIRST"),
                   .STARVE_LIMIT(LIM))
    u_wf (.clk(clk), .rstn(rstn), .bus(if_wf.slave));

  // Single-port RAMs, unregistered output
  logic [DW-1:0] ram_rr [DEPTH];
  logic [DW-1:0] ram_wf [DEPTH];

  always @(posedge clk) begin
    if (if_rr.ram_wr_en) ram_rr[if_rr.ram_addr] <= if_rr.ram_wr_data;
    else                 if_rr.ram_rd_data      <= ram_rr[if_rr.ram_addr];
  end

  always @(posedge clk) begin
    if (if_wf.ram_wr_en) ram_wf[if_wf.ram_addr] <= if_wf.ram_wr_data;
    else                 if_wf.ram_rd_data      <= ram_wf[if_wf.ram_addr];
  end

  // Reference model state, index 0 = RR instance, 1 = WR_FIRST instance
  logic [DW-1:0] mm [2][DEPTH];
  bit            m_last_wr [2];
  int unsigned   m_wr_lose [2];
  int unsigned   m_rd_lose [2];
  logic          m_wen     [2];
  logic [AW-1:0] m_addr    [2];
  logic [DW-1:0] m_wdata   [2];
  bit            sched_v   [2][4];
  logic [DW-1:0] sched_d   [2][4];
  bit            ew        [2];
  bit            er        [2];
  logic          obs_w     [2];
  logic          obs_r     [2];
  logic [DW-1:0] last_rd   [2];
  int unsigned   n_valid   [2];
  int unsigned   cnt_w     [2];
  int unsigned   cnt_r     [2];
  int unsigned   cyc = 0;

  task automatic chk(input int d, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, d, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last_wr[d] = 1'b0;
      m_wr_lose[d] = 0;
      m_rd_lose[d] = 0;
      m_wen[d]     = 1'b0;
      m_addr[d]    = '0;
      m_wdata[d]   = '0;
      for (int s = 0; s < 4; s++) sched_v[d][s] = 1'b0;
    end
  endtask

  // One clock: check at negedge, advance models at posedge, return just after
  task automatic tick();
    @(negedge clk);
    if (!rstn) model_reset();
    for (int d = 0; d < 2; d++) begin
      logic gw, gr, wen, vld;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, rdd;
      logic [3:0] rl;
      if (d == 0) begin
        gw = if_rr.wr_gnt; gr = if_rr.rd_gnt; wen = if_rr.ram_wr_en;
        vld = if_rr.rd_valid; a = if_rr.ram_addr; wd = if_rr.ram_wr_data;
        rdd = if_rr.rd_data; rl = u_rr.rd_lose_q;
      end else begin
        gw = if_wf.wr_gnt; gr = if_wf.rd_gnt; wen = if_wf.ram_wr_en;
        vld = if_wf.rd_valid; a = if_wf.ram_addr; wd = if_wf.ram_wr_data;
        rdd = if_wf.rd_data; rl = u_wf.rd_lose_q;
      end
      if (!rstn) begin
        ew[d] = 1'b0; er[d] = 1'b0;
      end else if (wr_req && rd_req) begin
        ew[d] = (d == 0) ? !m_last_wr[d] : (m_rd_lose[d] < LIM);
        er[d] = !ew[d];
      end else begin
        ew[d] = wr_req; er[d] = rd_req;
      end
      chk(d, "wr_gnt", 32'(gw), 32'(ew[d]));
      chk(d, "rd_gnt", 32'(gr), 32'(er[d]));
      chk(d, "ram_wr_en", 32'(wen), 32'(m_wen[d]));
      chk(d, "ram_addr", 32'(a), 32'(m_addr[d]));
      chk(d, "ram_wr_data", 32'(wd), 32'(m_wdata[d]));
      chk(d, "rd_valid", 32'(vld), 32'(sched_v[d][cyc % 4]));
      if (sched_v[d][cyc % 4]) chk(d, "rd_data", 32'(rdd), 32'(sched_d[d][cyc % 4]));
      chk(d, "rd_lose", 32'(rl), 32'(m_rd_lose[d]));
      sched_v[d][cyc % 4] = 1'b0;
      if (vld === 1'b1) begin
        last_rd[d] = rdd;
        n_valid[d]++;
      end
      obs_w[d] = gw;
      obs_r[d] = gr;
      if (gw === 1'b1) cnt_w[d]++;
      if (gr === 1'b1) cnt_r[d]++;
    end
    @(posedge clk);
    if (rstn) begin
      for (int d = 0; d < 2; d++) begin
        m_wen[d] = ew[d];
        if (ew[d]) begin
          m_addr[d]       = wr_addr;
          m_wdata[d]      = wr_data;
          mm[d][wr_addr]  = wr_data;
        end else if (er[d]) begin
          m_addr[d] = rd_addr;
          sched_v[d][(cyc + 2) % 4] = 1'b1;
          sched_d[d][(cyc + 2) % 4] = mm[d][rd_addr];
        end
        if (d == 0) begin
          if (ew[d])      m_last_wr[d] = 1'b1;
          else if (er[d]) m_last_wr[d] = 1'b0;
        end else begin
          m_rd_lose[d] = (rd_req && !er[d]) ?
                         ((m_rd_lose[d] < LIM) ? m_rd_lose[d] + 1 : LIM) : 0;
          m_wr_lose[d] = (wr_req && !ew[d]) ?
                         ((m_wr_lose[d] < LIM) ? m_wr_lose[d] + 1 : LIM) : 0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clear_tallies();
    for (int d = 0; d < 2; d++) begin
      n_valid[d] = 0; cnt_w[d] = 0; cnt_r[d] = 0;
    end
  endtask

  initial begin
    rstn = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram_rr[i] = DW'(i); ram_wf[i] = DW'(i);
      mm[0][i]  = DW'(i); mm[1][i]  = DW'(i);
    end
    model_reset();
    clear_tallies();

    // Reset held with both requesters active
    #1;
    rstn = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = AW'(12'h123); wr_data = 16'hBEEF; rd_addr = AW'(12'h123);
    repeat (3) tick();

    // Release: writer wins the first contest in both modes
    rstn = 1'b1;
    tick();
    chk(0, "first_gnt_wr", 32'(obs_w[0]), 32'd1);
    chk(1, "first_gnt_wr", 32'(obs_w[1]), 32'd1);

    // Read-after-write to 0x123 on the next cycle returns 0xBEEF
    wr_req = 1'b0;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    chk(0, "raw_data", 32'(last_rd[0]), 32'h0000BEEF);
    chk(1, "raw_data", 32'(last_rd[1]), 32'h0000BEEF);

    // Restore addr==data at 0x123
    wr_req = 1'b1; wr_data = 16'h0123;
    tick();
    wr_req = 1'b0;
    tick();

    // Streaming reads through the whole array and across the wrap
    clear_tallies();
    rd_req = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      rd_addr = AW'(i);
      tick();
    end
    rd_req = 1'b0;
    repeat (3) tick();
    chk(0, "stream_valids", n_valid[0], DEPTH + 2);
    chk(1, "stream_valids", n_valid[1], DEPTH + 2);
    chk(0, "stream_last", 32'(last_rd[0]), 32'd1);

    // Both requesters held continuously
    clear_tallies();
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_addr = AW'($urandom_range(0, 63));
      wr_data = DW'($urandom);
      rd_addr = AW'($urandom_range(0, 63));
      tick();
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) tick();
    chk(0, "rr_writes", cnt_w[0], 32'd5);
    chk(0, "rr_reads", cnt_r[0], 32'd5);
    chk(0, "rr_valids", n_valid[0], 32'd5);
    chk(1, "wf_writes", cnt_w[1], 32'd8);
    chk(1, "wf_reads", cnt_r[1], 32'd2);

    // Random traffic over a small address window to provoke hazards
    for (int i = 0; i < 500; i++) begin
      wr_req  = 1'($urandom_range(0, 1));
      rd_req  = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 15));
      rd_addr = AW'($urandom_range(0, 15));
      wr_data = DW'($urandom);
      tick();
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) tick();

    // Reset pulse one cycle after a read grant kills that read
    rd_req = 1'b1; rd_addr = AW'(5);
    tick();
    clear_tallies();
    rd_req = 1'b0; rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk(0, "killed_read", n_valid[0], 32'd0);
    chk(1, "killed_read", n_valid[1], 32'd0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (3) tick();
    chk(0, "post_reset_read", n_valid[0], 32'd1);
    chk(1, "post_reset_read", n_valid[1], 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
